i2s_rx_deser: RTL and testbench
===============================

I2S_RX_DESER -- requirements
Module: i2s_rx_deser

Interface
REQ-001 The block SHALL have these parameters:
- MAXW, default 32, maximum received word width in bits.
REQ-002 The block SHALL have these ports:
- sclk  in  1  serial bit clock; all logic on posedge.
- rst_  in  1  reset, asynchronous, active-low.
- sd  in  1  serial data line.
- ws  in  1  word select; 0 = left, 1 = right.
- rx_en  in  1  receive enable from ws control, used in MSB-justified mode.
- del_rx_en  in  1  receive enable delayed one cycle, used in Philips mode.
- philips  in  1  1 = Philips standard (MSB one cycle after ws edge); 0 = MSB-justified (MSB on ws edge).
- word_len  in  2  00 = 16, 01 = 24, 10 = 32 bits; 11 is treated as 32.
- rx_full  in  1  receive FIFO full.
- ovf_clr  in  1  clears the ovf and frame_err flags.
- rx_data  out  MAXW  received word, right-aligned, upper bits zero.
- rx_chan  out  1  channel of rx_data; equals the ws level of its slot.
- rx_wr  out  1  one-cycle FIFO write strobe.
- ovf  out  1  sticky: a word was dropped because rx_full was high.
- frame_err  out  1  sticky: ws toggled before word_len bits were received.

Function
REQ-003 Effective enable SHALL be en = philips ? del_rx_en : rx_en.
REQ-004 ws SHALL be registered into ws_d on every posedge; a ws edge is ws != ws_d.
REQ-005 States SHALL be IDLE, ALIGN, SHIFT and HOLD.
REQ-006 IDLE SHALL move to ALIGN when en=1; no bits are captured in IDLE.
REQ-007 ALIGN SHALL wait for a ws edge; a mid-slot start is never captured.
REQ-008 On a ws edge in ALIGN or HOLD:
- MSB-justified: the bit at that posedge is bit 0 (MSB); go to SHIFT with cnt=1.
- Philips: go to SHIFT with cnt=0, and the MSB is sampled at the next posedge.
- rx_chan for the slot is latched from ws.
REQ-009 In SHIFT, each posedge SHALL shift sd into the LSB of the shift register and increment cnt.
REQ-010 When the sample with cnt == N-1 is taken (N = word length):
- rx_data takes the assembled word.
- rx_wr is 1 for exactly one cycle, registered on that same posedge.
- The state goes to HOLD.
REQ-011 In HOLD, sd SHALL be ignored until the next ws edge; slot bits beyond N are discarded.
REQ-012 If rx_full=1 in the cycle rx_wr would assert:
- rx_wr stays 0 and the word is dropped.
- ovf is set.
REQ-013 If a ws edge occurs in SHIFT before N bits are taken:
- The partial word is discarded and rx_wr stays 0.
- frame_err is set.
- The edge is processed as a new slot start, per REQ-008.
REQ-014 If en falls in any state, the next state SHALL be IDLE and any partial word is discarded without an error flag.
REQ-015 word_len and philips SHALL be sampled only at slot start; changes mid-slot take effect from the next slot.
REQ-016 cnt SHALL be 6 bits and saturate; it never wraps.
REQ-017 ovf_clr SHALL clear ovf and frame_err.
REQ-018 When ovf_clr and a set event occur in the same cycle, the set SHALL win.
REQ-019 rx_data SHALL hold its value between strobes.

Reset
REQ-020 While rst_=0, the following SHALL all be 0:
- state = IDLE, ws_d, cnt, shift register.
- rx_data, rx_chan, rx_wr, ovf, frame_err.
REQ-021 Assertion of rst_ SHALL take effect immediately, regardless of sclk.
REQ-022 rst_ SHALL be released synchronously.
REQ-023 Reset asserted mid-word SHALL produce no rx_wr.

Verification
REQ-024 MSB-justified, 16-bit words, 32-bit slots, en=1, L=0xA5C3 and R=0x1234 sent -> rx_wr pulses with (0xA5C3, chan 0), then (0x1234, chan 1); each pulse is on the posedge that samples that word's 16th bit.
REQ-025 Philips, 24-bit words, L=0x800001 -> MSB is taken one cycle after the ws edge, rx_data=0x00800001, one pulse per slot.
REQ-026 rx_full=1 during the second word's strobe cycle -> no rx_wr and ovf=1; after ovf_clr, ovf=0.
REQ-027 32-bit words with ws toggling after 20 bits -> no rx_wr and frame_err=1; the following full slot is received correctly.
REQ-028 en starts mid-slot -> first word is captured only after the next ws edge; en drops mid-word -> no strobe and return to IDLE.
REQ-029 rst_ pulsed low mid-word -> all outputs are 0 immediately and no rx_wr; capture resumes after the next ws edge.

Source files
------------

// File: rtl/i2s_rx_deser.sv
// I2S receive deserializer: aligns to ws edges, shifts in MSB-first words of 16/24/32 bits,
// and hands each completed word to the receive FIFO with overflow and framing flags.
module i2s_rx_deser #(
    parameter int MAXW = 32
) (
    input  logic            sclk,
    input  logic            rst_,
    input  logic            sd,
    input  logic            ws,
    input  logic            rx_en,
    input  logic            del_rx_en,
    input  logic            philips,
    input  logic [1:0]      word_len,
    input  logic            rx_full,
    input  logic            ovf_clr,
    output logic [MAXW-1:0] rx_data,
    output logic            rx_chan,
    output logic            rx_wr,
    output logic            ovf,
    output logic            frame_err
);

    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, HOLD} state_t;

    state_t          state, state_nx;
    logic            rst_meta, rst_sync;
    logic            ws_d;
    logic [5:0]      cnt, cnt_nx, cnt_inc, last_cnt;
    logic [MAXW-1:0] shreg, shreg_nx, word_asm;
    logic [1:0]      slot_len, slot_len_nx;
    logic            slot_chan, slot_chan_nx;
    logic [MAXW-1:0] rx_data_nx;
    logic            rx_chan_nx, rx_wr_nx;
    logic            ovf_set, ferr_set, slot_start, en, ws_edge;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge sclk or negedge rst_) begin
        if (!rst_) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign en       = philips ? del_rx_en : rx_en;
    assign ws_edge  = (ws != ws_d);
    assign cnt_inc  = (cnt == 6'h3f) ? cnt : cnt + 6'd1;
    assign word_asm = {shreg[MAXW-2:0], sd};

    always_comb begin
        case (slot_len)
            2'b00:   last_cnt = 6'd15;
            2'b01:   last_cnt = 6'd23;
            default: last_cnt = 6'd31;
        endcase
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        shreg_nx     = shreg;
        slot_len_nx  = slot_len;
        slot_chan_nx = slot_chan;
        rx_data_nx   = rx_data;
        rx_chan_nx   = rx_chan;
        rx_wr_nx     = 1'b0;
        ovf_set      = 1'b0;
        ferr_set     = 1'b0;
        slot_start   = 1'b0;

        case (state)
            IDLE: begin
                state_nx = ALIGN;
            end
            ALIGN, HOLD: begin
                slot_start = ws_edge;
            end
            SHIFT: begin
                shreg_nx = word_asm;
                cnt_nx   = cnt_inc;
                if (cnt == last_cnt) begin
                    state_nx = HOLD;
                    if (rx_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        rx_wr_nx   = 1'b1;
                        rx_data_nx = word_asm;
                        rx_chan_nx = slot_chan;
                    end
                end else if (ws_edge) begin
                    ferr_set = 1'b1;
                end
                slot_start = ws_edge;
            end
            default: state_nx = IDLE;
        endcase

        // A slot edge restarts the word; in MSB-justified mode this posedge already carries the MSB.
        if (slot_start) begin
            state_nx     = SHIFT;
            slot_len_nx  = word_len;
            slot_chan_nx = ws;
            if (philips) begin
                cnt_nx   = 6'd0;
                shreg_nx = '0;
            end else begin
                cnt_nx   = 6'd1;
                shreg_nx = {{(MAXW-1){1'b0}}, sd};
            end
        end

        if (!en) begin
            state_nx   = IDLE;
            cnt_nx     = 6'd0;
            shreg_nx   = '0;
            rx_data_nx = rx_data;
            rx_chan_nx = rx_chan;
            rx_wr_nx   = 1'b0;
            ovf_set    = 1'b0;
            ferr_set   = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge rst_sync) begin
        if (!rst_sync) begin
            state     <= IDLE;
            ws_d      <= 1'b0;
            cnt       <= 6'd0;
            shreg     <= '0;
            slot_len  <= 2'b00;
            slot_chan <= 1'b0;
            rx_data   <= '0;
            rx_chan   <= 1'b0;
            rx_wr     <= 1'b0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            ws_d      <= ws;
            cnt       <= cnt_nx;
            shreg     <= shreg_nx;
            slot_len  <= slot_len_nx;
            slot_chan <= slot_chan_nx;
            rx_data   <= rx_data_nx;
            rx_chan   <= rx_chan_nx;
            rx_wr     <= rx_wr_nx;
            // Setting beats clearing when both land in one cycle.
            ovf       <= ovf_set  ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
            frame_err <= ferr_set ? 1'b1 : (ovf_clr ? 1'b0 : frame_err);
        end
    end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed bench for i2s_rx_deser: drives whole I2S slots bit by bit and checks every
// FIFO write against hand-computed words, channels and strobe cycles.
module tb_i2s_rx_deser;

    logic        sclk = 1'b0;
    logic        rst_ = 1'b0;
    logic        sd = 1'b0;
    logic        ws = 1'b0;
    logic        rx_en = 1'b0;
    logic        del_rx_en = 1'b0;
    logic        philips = 1'b0;
    logic [1:0]  word_len = 2'b00;
    logic        rx_full = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] rx_data;
    logic        rx_chan, rx_wr, ovf, frame_err;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          wr_cyc = -1;
    logic [31:0] wr_data = '0;
    logic        wr_chan = 1'b0;
    int          base;

    i2s_rx_deser #(.MAXW(32)) dut (
        .sclk(sclk), .rst_(rst_), .sd(sd), .ws(ws), .rx_en(rx_en),
        .del_rx_en(del_rx_en), .philips(philips), .word_len(word_len),
        .rx_full(rx_full), .ovf_clr(ovf_clr), .rx_data(rx_data),
        .rx_chan(rx_chan), .rx_wr(rx_wr), .ovf(ovf), .frame_err(frame_err)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    // Logs every write strobe with the cycle it appeared on.
    always @(posedge sclk) begin
        #1;
        if (rx_wr === 1'b1) begin
            wr_count = wr_count + 1;
            wr_data  = rx_data;
            wr_chan  = rx_chan;
            wr_cyc   = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic driveBit(input logic ws_v, input logic sd_v);
        @(negedge sclk);
        ws = ws_v;
        sd = sd_v;
        @(posedge sclk);
        #1;
    endtask

    // One slot: Philips slots lead with one dummy bit after the ws edge before the MSB.
    task automatic applyStimulus(input string tag, input logic ws_v, input logic [31:0] word,
                                 input int nbits, input int slot_bits, input logic phil,
                                 input logic expect_wr);
        int start_cnt;
        int exp_cyc;
        start_cnt = wr_count;
        exp_cyc   = -1;
        for (int i = 0; i < slot_bits; i++) begin
            int   b;
            logic bit_v;
            b     = phil ? i - 1 : i;
            bit_v = 1'b0;
            if (b >= 0 && b < nbits) bit_v = word[nbits-1-b];
            driveBit(ws_v, bit_v);
            if (b == nbits - 1) exp_cyc = cyc;
        end
        #1;
        if (expect_wr) begin
            checkOutput({tag, " count"}, wr_count, start_cnt + 1);
            checkOutput({tag, " data"}, wr_data, word);
            checkOutput({tag, " chan"}, {31'b0, wr_chan}, {31'b0, ws_v});
            checkOutput({tag, " strobe cycle"}, wr_cyc, exp_cyc);
        end else begin
            checkOutput({tag, " no strobe"}, wr_count, start_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) driveBit(1'b0, 1'b1);
        checkOutput("reset rx_data", rx_data, 32'h0);
        checkOutput("reset rx_chan", {31'b0, rx_chan}, 32'h0);
        checkOutput("reset rx_wr", {31'b0, rx_wr}, 32'h0);
        checkOutput("reset ovf", {31'b0, ovf}, 32'h0);
        checkOutput("reset frame_err", {31'b0, frame_err}, 32'h0);

        rst_ = 1'b1;
        for (int i = 0; i < 3; i++) driveBit(1'b0, 1'b0);
        rx_en = 1'b1;
        for (int i = 0; i < 4; i++) driveBit(1'b0, 1'b0);

        // MSB-justified, 16-bit words in 32-bit slots.
        applyStimulus("warmup R", 1'b1, 32'h0000FFFF, 16, 32, 1'b0, 1'b1);
        applyStimulus("msbj L", 1'b0, 32'h0000A5C3, 16, 32, 1'b0, 1'b1);
        applyStimulus("msbj R", 1'b1, 32'h00001234, 16, 32, 1'b0, 1'b1);

        // Philips, 24-bit words.
        philips = 1'b1; del_rx_en = 1'b1; word_len = 2'b01;
        applyStimulus("phil L", 1'b0, 32'h00800001, 24, 32, 1'b1, 1'b1);
        applyStimulus("phil R", 1'b1, 32'h005A5A5A, 24, 32, 1'b1, 1'b1);

        // Overflow: second word arrives while the FIFO is full.
        philips = 1'b0; word_len = 2'b00;
        applyStimulus("ovf L", 1'b0, 32'h00001111, 16, 32, 1'b0, 1'b1);
        rx_full = 1'b1;
        applyStimulus("ovf R", 1'b1, 32'h00002222, 16, 32, 1'b0, 1'b0);
        rx_full = 1'b0;
        checkOutput("ovf set", {31'b0, ovf}, 32'h1);
        checkOutput("ovf data held", rx_data, 32'h00001111);
        ovf_clr = 1'b1;
        driveBit(1'b1, 1'b0);
        ovf_clr = 1'b0;
        #1;
        checkOutput("ovf cleared", {31'b0, ovf}, 32'h0);

        // Framing error: 32-bit word cut short after 20 bits.
        word_len = 2'b10;
        applyStimulus("short L", 1'b0, 32'hDEADBEEF, 32, 20, 1'b0, 1'b0);
        checkOutput("ferr before edge", {31'b0, frame_err}, 32'h0);
        applyStimulus("after ferr R", 1'b1, 32'hCAFEF00D, 32, 32, 1'b0, 1'b1);
        checkOutput("ferr set", {31'b0, frame_err}, 32'h1);
        checkOutput("ferr no ovf", {31'b0, ovf}, 32'h0);
        ovf_clr = 1'b1;
        driveBit(1'b1, 1'b0);
        ovf_clr = 1'b0;
        #1;
        checkOutput("ferr cleared", {31'b0, frame_err}, 32'h0);

        // Enable rising mid-slot must wait for the next ws edge.
        rx_en = 1'b0; word_len = 2'b00;
        driveBit(1'b1, 1'b0);
        driveBit(1'b1, 1'b0);
        rx_en = 1'b1;
        base = wr_count;
        for (int i = 0; i < 20; i++) driveBit(1'b1, 1'b1);
        #1;
        checkOutput("midslot en no strobe", wr_count, base);
        applyStimulus("en L", 1'b0, 32'h0000BEEF, 16, 32, 1'b0, 1'b1);

        // Enable dropping mid-word discards the word and re-aligns.
        base = wr_count;
        for (int i = 0; i < 8; i++) driveBit(1'b1, 1'b1);
        rx_en = 1'b0;
        for (int i = 0; i < 12; i++) driveBit(1'b1, 1'b1);
        rx_en = 1'b1;
        for (int i = 0; i < 12; i++) driveBit(1'b1, 1'b1);
        #1;
        checkOutput("en drop no strobe", wr_count, base);
        checkOutput("en drop data held", rx_data, 32'h0000BEEF);
        checkOutput("en drop no ferr", {31'b0, frame_err}, 32'h0);

        // Reset mid-word clears outputs at once and drops the partial word.
        base = wr_count;
        for (int i = 0; i < 8; i++) driveBit(1'b0, 1'b1);
        rst_ = 1'b0;
        #2;
        checkOutput("async rst rx_data", rx_data, 32'h0);
        checkOutput("async rst rx_wr", {31'b0, rx_wr}, 32'h0);
        driveBit(1'b0, 1'b1);
        driveBit(1'b0, 1'b1);
        rst_ = 1'b1;
        for (int i = 0; i < 14; i++) driveBit(1'b0, 1'b1);
        #1;
        checkOutput("rst no strobe", wr_count, base);
        applyStimulus("post rst R", 1'b1, 32'h00004321, 16, 32, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
